// File: rtl/config_pkg.sv
// Shared configuration and scoreboard types for the retirement path.
package config_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    ALU,
    BRANCH,
    LOAD,
    STORE,
    CSR,
    MULT
  } fu_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
  } exception_t;

  typedef struct packed {
    logic            valid;
    logic            done;
    fu_t             fu;
    logic [4:0]      rd;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] pc;
    exception_t      ex;
  } scoreboard_entry_t;

endpackage

// File: rtl/commit_if.sv
// Commit-side bundle: scoreboard head in, retirement side effects out.
interface commit_if;
  import config_pkg::*;

  logic              halt_i;
  scoreboard_entry_t commit_instr_i;
  logic              commit_ack_o;
  logic              we_gpr_o;
  logic [4:0]        waddr_o;
  logic [XLEN-1:0]   wdata_o;
  logic              commit_store_o;
  logic              commit_store_ack_i;
  logic              csr_commit_o;
  exception_t        exception_o;
  logic [XLEN-1:0]   epc_o;
  logic              flush_o;
  logic [63:0]       instret_o;

  // Environment side: scoreboard, store buffer and debug controller.
  modport master (
    output halt_i, commit_instr_i, commit_store_ack_i,
    input  commit_ack_o, we_gpr_o, waddr_o, wdata_o, commit_store_o,
           csr_commit_o, exception_o, epc_o, flush_o, instret_o
  );

  // Retirement unit side.
  modport slave (
    input  halt_i, commit_instr_i, commit_store_ack_i,
    output commit_ack_o, we_gpr_o, waddr_o, wdata_o, commit_store_o,
           csr_commit_o, exception_o, epc_o, flush_o, instret_o
  );

endinterface

// File: rtl/commit_stage.sv
// In-order retirement of the scoreboard head: GPR writeback, store commit,
// exception raise and post-CSR flush, plus the retired-instruction counter.
//
// state      | meaning
// RUN        | inspect head, retire eligible instruction this cycle
// WAIT_STORE | store commit requested, holding until store buffer acks
// POST_FLUSH | one-cycle flush after a CSR retirement, nothing retires
module commit_stage
  import config_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_ni,
  commit_if.slave  cif
);

  typedef enum logic [1:0] {
    RUN,
    WAIT_STORE,
    POST_FLUSH
  } state_t;

  state_t            state_q;
  logic [63:0]       instret_q;
  scoreboard_entry_t head;
  logic              eligible;
  logic              ack;
  logic              we;
  logic              store_req;
  logic              csr_commit;
  logic              flush;
  logic [4:0]        waddr;
  logic [XLEN-1:0]   wdata;
  logic [XLEN-1:0]   epc;
  exception_t        ex;

  assign head = cif.commit_instr_i;
  // Gating with rst_ni keeps every request low while reset is held, so a
  // pending store commit disappears the moment reset asserts.
  assign eligible = head.valid & head.done & ~cif.halt_i & rst_ni;

  // Retirement decision for the current head and state.
  always_comb begin
    ack        = 1'b0;
    we         = 1'b0;
    store_req  = 1'b0;
    csr_commit = 1'b0;
    flush      = 1'b0;
    waddr      = '0;
    wdata      = '0;
    epc        = '0;
    ex         = '0;
    unique case (state_q)
      RUN: begin
        if (eligible) begin
          if (head.ex.valid) begin
            ex    = head.ex;
            epc   = head.pc;
            ack   = 1'b1;
            flush = 1'b1;
          end else if (head.fu == STORE) begin
            store_req = 1'b1;
            ack       = cif.commit_store_ack_i;
          end else begin
            ack        = 1'b1;
            we         = |head.rd;
            csr_commit = (head.fu == CSR);
          end
        end
      end
      WAIT_STORE: begin
        // halt_i is deliberately ignored: a started store always completes.
        store_req = 1'b1;
        ack       = cif.commit_store_ack_i & head.valid;
      end
      POST_FLUSH: flush = 1'b1;
      default: ;
    endcase
    if (we) begin
      waddr = head.rd;
      wdata = head.result;
    end
  end

  // State advance and retired-instruction counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RUN;
      instret_q <= '0;
    end else begin
      if (ack && !ex.valid) instret_q <= instret_q + 64'd1;
      unique case (state_q)
        RUN: begin
          if (eligible && !head.ex.valid) begin
            if (head.fu == STORE && !cif.commit_store_ack_i) state_q <= WAIT_STORE;
            else if (head.fu == CSR)                          state_q <= POST_FLUSH;
          end
        end
        WAIT_STORE: if (cif.commit_store_ack_i) state_q <= RUN;
        POST_FLUSH: state_q <= RUN;
        default:    state_q <= RUN;
      endcase
    end
  end

  assign cif.commit_ack_o   = ack;
  assign cif.we_gpr_o       = we;
  assign cif.waddr_o        = waddr;
  assign cif.wdata_o        = wdata;
  assign cif.commit_store_o = store_req;
  assign cif.csr_commit_o   = csr_commit;
  assign cif.exception_o    = ex;
  assign cif.epc_o          = epc;
  assign cif.flush_o        = flush;
  assign cif.instret_o      = instret_q;

endmodule

// File: tb/tb_commit_stage.sv
// Randomized and directed checks of commit_stage against a reference model.
module tb_commit_stage;
  import config_pkg::*;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  commit_if cif ();

  commit_stage dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .cif    (cif)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: whether a store commit is outstanding, whether a flush
  // is owed after a CSR, and the architectural retired count.
  logic        m_wait;
  logic        m_flush;
  logic [63:0] m_instret;
  logic        last_store;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_head(input logic v, input logic d, input fu_t fu, input logic [4:0] rd,
                          input logic [XLEN-1:0] res, input logic [XLEN-1:0] pc,
                          input logic exv, input logic [XLEN-1:0] cause);
    scoreboard_entry_t h;
    h.valid = v; h.done = d; h.fu = fu; h.rd = rd; h.result = res; h.pc = pc;
    h.ex.valid = exv; h.ex.cause = cause; h.ex.tval = pc;
    cif.commit_instr_i = h;
  endtask

  // Inputs are already applied (at a negedge); predict, check, advance model.
  task automatic cycle(output logic acked);
    scoreboard_entry_t h;
    logic e_ack, e_we, e_store, e_csr, e_flush, n_wait, n_flush, sack;
    logic [4:0] e_waddr;
    logic [XLEN-1:0] e_wdata, e_epc;
    exception_t e_ex;
    h = cif.commit_instr_i;
    sack = cif.commit_store_ack_i;
    e_ack = 0; e_we = 0; e_store = 0; e_csr = 0; e_flush = 0;
    e_waddr = '0; e_wdata = '0; e_epc = '0; e_ex = '0;
    n_wait = m_wait; n_flush = 1'b0;
    if (m_flush) begin
      e_flush = 1;
    end else if (m_wait) begin
      e_store = 1;
      if (sack) begin e_ack = h.valid; n_wait = 0; end
    end else if (h.valid && h.done && !cif.halt_i) begin
      if (h.ex.valid) begin
        e_ex = h.ex; e_epc = h.pc; e_ack = 1; e_flush = 1;
      end else if (h.fu == STORE) begin
        e_store = 1;
        if (sack) e_ack = 1; else n_wait = 1;
      end else begin
        e_ack = 1;
        e_we = (h.rd != 5'd0);
        if (e_we) begin e_waddr = h.rd; e_wdata = h.result; end
        if (h.fu == CSR) begin e_csr = 1; n_flush = 1; end
      end
    end
    #1;
    check_eq("ack",      64'(cif.commit_ack_o),      64'(e_ack));
    check_eq("we_gpr",   64'(cif.we_gpr_o),          64'(e_we));
    check_eq("waddr",    64'(cif.waddr_o),           64'(e_waddr));
    check_eq("wdata",    64'(cif.wdata_o),           64'(e_wdata));
    check_eq("c_store",  64'(cif.commit_store_o),    64'(e_store));
    check_eq("csr",      64'(cif.csr_commit_o),      64'(e_csr));
    check_eq("flush",    64'(cif.flush_o),           64'(e_flush));
    check_eq("ex_valid", 64'(cif.exception_o.valid), 64'(e_ex.valid));
    check_eq("ex_cause", 64'(cif.exception_o.cause), 64'(e_ex.cause));
    check_eq("ex_tval",  64'(cif.exception_o.tval),  64'(e_ex.tval));
    check_eq("epc",      64'(cif.epc_o),             64'(e_epc));
    check_eq("instret",  cif.instret_o,              m_instret);
    last_store = cif.commit_store_o;
    if (e_ack && !e_ex.valid) m_instret = m_instret + 64'd1;
    m_wait  = n_wait;
    m_flush = n_flush;
    acked   = e_ack;
    @(negedge clk_i);
  endtask

  logic              acked;
  logic              have;
  int                store_cnt;
  scoreboard_entry_t rh;

  initial begin
    m_wait = 0; m_flush = 0; m_instret = '0; last_store = 0;
    rst_ni = 1'b0;
    cif.halt_i = 1'b0;
    cif.commit_store_ack_i = 1'b0;
    cif.commit_instr_i = '0;
    #12;
    check_eq("rst_ack",     64'(cif.commit_ack_o),   64'd0);
    check_eq("rst_store",   64'(cif.commit_store_o), 64'd0);
    check_eq("rst_flush",   64'(cif.flush_o),        64'd0);
    check_eq("rst_instret", cif.instret_o,           64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // ALU head, rd=5
    set_head(1, 1, ALU, 5'd5, 32'hDEAD_BEEF, 32'h100, 0, '0);
    cycle(acked);
    check_eq("alu_instret", cif.instret_o, 64'd1);
    // ALU head, rd=0
    set_head(1, 1, ALU, 5'd0, 32'h1234, 32'h104, 0, '0);
    cycle(acked);
    // not-done head for 4 cycles, then done
    set_head(1, 0, BRANCH, 5'd7, 32'h55, 32'h108, 0, '0);
    repeat (4) cycle(acked);
    set_head(1, 1, BRANCH, 5'd7, 32'h55, 32'h108, 0, '0);
    cycle(acked);

    // STORE: store ack low 3 cycles, halt in cycle 2, ack in cycle 4
    store_cnt = 0;
    set_head(1, 1, STORE, 5'd9, 32'h77, 32'h10C, 0, '0);
    for (int c = 1; c <= 4; c++) begin
      cif.halt_i = (c == 2);
      cif.commit_store_ack_i = (c == 4);
      cycle(acked);
      if (last_store) store_cnt++;
    end
    cif.halt_i = 0; cif.commit_store_ack_i = 0;
    check_eq("store_hold", 64'(store_cnt), 64'd4);

    // Excepting STORE
    set_head(1, 1, STORE, 5'd2, 32'h0, 32'h8000_0010, 1, 32'd2);
    cycle(acked);
    check_eq("ex_instret", cif.instret_o, 64'd4);

    // CSR then flush cycle then normal resume
    set_head(1, 1, CSR, 5'd3, 32'h1800, 32'h110, 0, '0);
    cycle(acked);
    set_head(1, 1, ALU, 5'd4, 32'hAA, 32'h114, 0, '0);
    cycle(acked);
    cycle(acked);

    // Reset while waiting on a store
    set_head(1, 1, STORE, 5'd0, 32'h0, 32'h118, 0, '0);
    cycle(acked);
    #2 rst_ni = 1'b0;
    #1;
    check_eq("rst_mid_store",   64'(cif.commit_store_o), 64'd0);
    check_eq("rst_mid_instret", cif.instret_o,           64'd0);
    m_wait = 0; m_flush = 0; m_instret = '0;
    cif.commit_instr_i = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    cycle(acked);
    set_head(1, 1, ALU, 5'd1, 32'h42, 32'h11C, 0, '0);
    cycle(acked);

    // Randomized scoreboard head stream
    have = 0;
    rh = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!have) begin
        rh.valid     = ($urandom_range(0, 9) < 8);
        rh.done      = 1'($urandom_range(0, 1));
        rh.fu        = fu_t'($urandom_range(0, 5));
        rh.rd        = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        rh.result    = XLEN'($urandom);
        rh.pc        = XLEN'($urandom);
        rh.ex.valid  = ($urandom_range(0, 9) == 0);
        rh.ex.cause  = XLEN'($urandom_range(0, 15));
        rh.ex.tval   = XLEN'($urandom);
        have         = rh.valid;
      end else if (!rh.done) begin
        rh.done = ($urandom_range(0, 2) == 0);
      end
      cif.commit_instr_i     = rh;
      cif.halt_i             = ($urandom_range(0, 5) == 0);
      cif.commit_store_ack_i = 1'($urandom_range(0, 1));
      cycle(acked);
      if (acked) have = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
